wrap_shift_xor_engine: RTL and testbench
========================================

Name: wrap_shift_xor_engine

Overview:
Multi-channel successor to the two-lane initial shift stage of the sparse polynomial multiplier. For each of NUM_CH accumulator lanes it builds a wrap-around word from three shared operand words: word zero, last full word, and the partial tail word. It XORs that word into the lane's accumulator word. The block sits between the operand/accumulator RAM readers and the accumulator write-back, with valid/ready on both sides.

Parameters:
WORD_WIDTH, 32, data word width W
TAIL_BITS, 5, valid bits in the partial tail word T (1..W-1)
NUM_CH, 2, number of accumulator lanes processed per request
SHIFT_W, 16, width of each lane's shift amount
IDX_W, $clog2(WORD_WIDTH), width of each lane's shift index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request
word_zero  in  W  operand word 0
word_last  in  W  last full operand word
word_tail  in  W  partial tail word; bits [T-1:0] are meaningful
acc_words  in  NUM_CH*W  accumulator words; lane c is at [c*W +: W]
shift  in  NUM_CH*SHIFT_W  per-lane shift amount
shift_idx  in  NUM_CH*IDX_W  per-lane shift index s
out_valid  out  1  results valid
out_ready  in  1  consumer accepts the results
result  out  NUM_CH*W  per-lane acc XOR extracted word
err  out  NUM_CH  per-lane illegal-index flag, valid with out_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, err=0, internal registers 0.
- Request capture: a request is accepted on any edge where in_valid && in_ready. On accept, all inputs are latched and in_ready drops to 0. Inputs are ignored while busy.
- Lane arithmetic: let r = shift[c][IDX_W-1:0], s = shift_idx[c], and mask(n) = (1<<n)-1, computed in W+1 bits so that mask(W) is all ones.
  - Case r >= T: E = ((zero & mask(s)) << (W-s)) | (tail[T-1:0] << (W-T-s)) | ((last >> (T+s)) & mask(W-T-s)).
  - Case r < T: E = ((zero & mask(s)) << r) | ((tail >> (T-r)) & mask(r)).
  - Any term shifted by W or more is 0. In particular, the zero-word term is 0 when s=0.
  - Illegal index: if r >= T and s > W-T, set err[c]=1 and result[c]=acc[c] (no change).
  - Otherwise: err[c]=0 and result[c] = acc[c] ^ E.
- FSM states: IDLE -> EXTRACT -> COMBINE -> (next lane: EXTRACT | last lane: HOLD) -> IDLE.
  - EXTRACT registers E and the illegal flag for lane ch.
  - COMBINE writes result[ch] and err[ch], then increments ch.
  - ch is a lane counter running 0..NUM_CH-1 and is cleared on accept.
- Latency: out_valid rises 2*NUM_CH cycles after the accepting edge.
- HOLD state:
  - out_valid=1 while in HOLD; result and err are stable.
  - Leaves HOLD on the edge where out_valid && out_ready. On that edge out_valid goes to 0, in_ready goes to 1 and the state returns to IDLE.
  - A new request can be accepted one cycle after that edge, not on the same cycle.
- Output stability: result lanes are only written in COMBINE. Lanes not yet reprocessed keep their previous values but are not valid until out_valid.
- Reset mid-operation: aborts immediately to the reset values. No partial results are presented.
- NUM_CH=1: the sequence is EXTRACT, COMBINE, HOLD.

Optional Feature:
WSX_FAST_EN
- Defined: EXTRACT and COMBINE merge into a single state that computes E and writes the result in the same cycle. out_valid rises NUM_CH cycles after accept. All other rules are unchanged.
- Undefined: two-cycle-per-lane registered flow as described above. This is the timing-safe default.

Decomposition:
- Package wsx_pkg: state enum (IDLE, EXTRACT, COMBINE, HOLD), localparams IDX_W and the legal-index limit W-T, and a mask helper function.
- Sub-module wsx_extract: purely combinational. Inputs: zero, last, tail, r, s. Outputs: E and the illegal flag. One instance is shared across lanes and driven from the lane-selected latched inputs.

Test Plan:
All scenarios use W=32, T=5, NUM_CH=2.
- Short-shift branch: lane0 shift=3, s=4, zero=0xF, tail=0x1F, acc=0 -> result0=0x0000007F, err0=0.
- Wrap branch: lane1 shift=8, s=4, zero=0xA, tail=0x15, last=0xFFFFFFFF, acc=0xFFFFFFFF -> result1=0x55000000, err1=0. out_valid rises 4 cycles after accept, or 2 cycles with WSX_FAST_EN.
- s=0 edge: shift=5, s=0, zero=0xFFFFFFFF, tail=0x1F, last=0, acc=0 -> result=0xF8000000 (the zero-word term vanishes).
- Illegal index: shift=7, s=30, acc=0x12345678 -> err=1, result=0x12345678. The other lane is processed normally.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result held constant, in_ready=0, and an extra in_valid pulse is ignored. out_ready=1 -> one handshake, then in_ready=1 the next cycle.
- Reset mid-run: assert rst_n=0 during lane-1 EXTRACT -> out_valid=0, result=0, err=0, in_ready=1 immediately. The next request completes correctly.

Source files
------------

// File: rtl/wsx_pkg.sv
// Package for wrap_shift_xor_engine.
// Holds the FSM state type, default geometry constants and the mask helper
// shared by the top level and the extractor.
// Optional feature macro: WSX_FAST_EN (merges EXTRACT and COMBINE into one state).
package wsx_pkg;

    localparam int unsigned WSX_WORD_WIDTH = 32;
    localparam int unsigned WSX_TAIL_BITS  = 5;
    localparam int unsigned WSX_IDX_W      = $clog2(WSX_WORD_WIDTH);
    // Largest legal shift index when the wrap branch is taken (W-T).
    localparam int unsigned S_LIMIT        = WSX_WORD_WIDTH - WSX_TAIL_BITS;

    typedef enum logic [1:0] {
        StIdle,
        StExtract,
        StCombine,
        StHold
    } wsx_state_e;

    // (1<<n)-1 in a wide container, so that mask_n(W) is all ones for any W < 64.
    function automatic logic [63:0] mask_n(input int unsigned n);
        if (n >= 64) begin
            return '1;
        end
        return (64'd1 << n) - 64'd1;
    endfunction

endpackage

// File: rtl/wsx_if.sv
// Request/response bus of wrap_shift_xor_engine.
// master: requester side (drives request fields and out_ready).
// slave : engine side (drives in_ready, out_valid, result, err).
interface wsx_if #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SHIFT_W    = 16,
    parameter int unsigned IDX_W      = $clog2(WORD_WIDTH)
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [WORD_WIDTH-1:0]         word_zero;
    logic [WORD_WIDTH-1:0]         word_last;
    logic [WORD_WIDTH-1:0]         word_tail;
    logic [NUM_CH*WORD_WIDTH-1:0]  acc_words;
    logic [NUM_CH*SHIFT_W-1:0]     shift;
    logic [NUM_CH*IDX_W-1:0]       shift_idx;
    logic                          out_valid;
    logic                          out_ready;
    logic [NUM_CH*WORD_WIDTH-1:0]  result;
    logic [NUM_CH-1:0]             err;

    modport master (
        output in_valid, word_zero, word_last, word_tail, acc_words, shift, shift_idx,
        output out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, word_zero, word_last, word_tail, acc_words, shift, shift_idx,
        input  out_ready,
        output in_ready, out_valid, result, err
    );

endinterface

// File: rtl/wsx_extract.sv
// Combinational wrap-around word extractor for one lane.
// Ports: zero/last/tail operand words, r (shift low bits), s (shift index);
//        e = extracted word, illegal = wrap branch with s beyond W-T.
module wsx_extract
    import wsx_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WSX_WORD_WIDTH,
    parameter int unsigned TAIL_BITS  = WSX_TAIL_BITS,
    parameter int unsigned IDX_W      = $clog2(WORD_WIDTH),
    parameter int unsigned S_MAX      = S_LIMIT
) (
    input  logic [WORD_WIDTH-1:0] zero,
    input  logic [WORD_WIDTH-1:0] last,
    input  logic [WORD_WIDTH-1:0] tail,
    input  logic [IDX_W-1:0]      r,
    input  logic [IDX_W-1:0]      s,
    output logic [WORD_WIDTH-1:0] e,
    output logic                  illegal
);

    int unsigned           ri, si, lo_w;
    logic [WORD_WIDTH-1:0] zm, tail_m, mask_lo, mask_r;

    always_comb begin
        ri      = 32'(r);
        si      = 32'(s);
        zm      = zero & WORD_WIDTH'(mask_n(si));
        tail_m  = tail & WORD_WIDTH'(mask_n(TAIL_BITS));
        mask_r  = WORD_WIDTH'(mask_n(ri));
        lo_w    = 0;
        mask_lo = '0;
        e       = '0;
        illegal = 1'b0;
        if (ri >= TAIL_BITS) begin
            if (si > S_MAX) begin
                illegal = 1'b1;
            end else begin
                lo_w    = WORD_WIDTH - TAIL_BITS - si;
                mask_lo = WORD_WIDTH'(mask_n(lo_w));
                // Shifts of W or more yield zero, which drops the zero-word term at s=0.
                e = (zm << (WORD_WIDTH - si)) | (tail_m << lo_w) |
                    ((last >> (TAIL_BITS + si)) & mask_lo);
            end
        end else begin
            e = (zm << ri) | ((tail_m >> (TAIL_BITS - ri)) & mask_r);
        end
    end

endmodule

// File: rtl/wrap_shift_xor_engine.sv
// Multi-lane wrap-around shift/XOR engine.
// Latches one request (shared operand words plus per-lane acc/shift/index),
// then walks the lanes one at a time through a single shared extractor,
// writing result[c] = acc[c] ^ E (or acc[c] with err[c]=1 on an illegal index).
// Ports: clk, rst_n (async, active-low), bus (wsx_if.slave: request and response).
// Optional feature macro: WSX_FAST_EN -- one cycle per lane instead of two.
module wrap_shift_xor_engine
    import wsx_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WSX_WORD_WIDTH,
    parameter int unsigned TAIL_BITS  = WSX_TAIL_BITS,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned SHIFT_W    = 16,
    parameter int unsigned IDX_W      = $clog2(WORD_WIDTH)
) (
    input  logic   clk,
    input  logic   rst_n,
    wsx_if.slave   bus
);

    localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    wsx_state_e                   state_q, state_d;
    logic [CH_W-1:0]              ch_q;
    logic [WORD_WIDTH-1:0]        zero_q, last_q, tail_q;
    logic [NUM_CH*WORD_WIDTH-1:0] acc_q, result_q;
    logic [NUM_CH*IDX_W-1:0]      r_q, s_q;
    logic [NUM_CH-1:0]            err_q;

    logic [IDX_W-1:0]             lane_r, lane_s;
    logic [WORD_WIDTH-1:0]        lane_e, lane_acc;
    logic                         lane_ill;
    logic                         last_lane;
    logic                         accept;

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = (state_q == StHold);
    assign bus.result    = result_q;
    assign bus.err       = err_q;

    assign accept    = bus.in_valid && (state_q == StIdle);
    assign last_lane = (ch_q == CH_W'(NUM_CH - 1));
    assign lane_r    = r_q[ch_q*IDX_W +: IDX_W];
    assign lane_s    = s_q[ch_q*IDX_W +: IDX_W];
    assign lane_acc  = acc_q[ch_q*WORD_WIDTH +: WORD_WIDTH];

    wsx_extract #(
        .WORD_WIDTH (WORD_WIDTH),
        .TAIL_BITS  (TAIL_BITS),
        .IDX_W      (IDX_W),
        .S_MAX      (WORD_WIDTH - TAIL_BITS)
    ) u_extract (
        .zero    (zero_q),
        .last    (last_q),
        .tail    (tail_q),
        .r       (lane_r),
        .s       (lane_s),
        .e       (lane_e),
        .illegal (lane_ill)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.in_valid) state_d = StExtract;
`ifdef WSX_FAST_EN
            StExtract: state_d = last_lane ? StHold : StExtract;
`else
            StExtract: state_d = StCombine;
`endif
            StCombine: state_d = last_lane ? StHold : StExtract;
            StHold:    if (bus.out_ready) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

`ifndef WSX_FAST_EN
    logic [WORD_WIDTH-1:0] e_q;
    logic                  ill_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            ch_q     <= '0;
            zero_q   <= '0;
            last_q   <= '0;
            tail_q   <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            s_q      <= '0;
            result_q <= '0;
            err_q    <= '0;
`ifndef WSX_FAST_EN
            e_q      <= '0;
            ill_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                zero_q <= bus.word_zero;
                last_q <= bus.word_last;
                tail_q <= bus.word_tail;
                acc_q  <= bus.acc_words;
                s_q    <= bus.shift_idx;
                ch_q   <= '0;
                // Only the low IDX_W bits of each lane's shift take part in extraction.
                for (int c = 0; c < NUM_CH; c++) begin
                    r_q[c*IDX_W +: IDX_W] <= bus.shift[c*SHIFT_W +: IDX_W];
                end
            end
`ifdef WSX_FAST_EN
            if (state_q == StExtract) begin
                result_q[ch_q*WORD_WIDTH +: WORD_WIDTH] <= lane_acc ^ (lane_e & {WORD_WIDTH{~lane_ill}});
                err_q[ch_q] <= lane_ill;
                if (!last_lane) ch_q <= ch_q + CH_W'(1);
            end
`else
            if (state_q == StExtract) begin
                e_q   <= lane_e;
                ill_q <= lane_ill;
            end
            if (state_q == StCombine) begin
                result_q[ch_q*WORD_WIDTH +: WORD_WIDTH] <= lane_acc ^ (e_q & {WORD_WIDTH{~ill_q}});
                err_q[ch_q] <= ill_q;
                if (!last_lane) ch_q <= ch_q + CH_W'(1);
            end
`endif
        end
    end

endmodule

// File: tb/tb_wrap_shift_xor_engine.sv
// Directed bench for wrap_shift_xor_engine (W=32, T=5, NUM_CH=2).
module tb_wrap_shift_xor_engine;

`ifdef WSX_FAST_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 4;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    wsx_if #(.WORD_WIDTH(32), .NUM_CH(2), .SHIFT_W(16), .IDX_W(5)) bus ();

    wrap_shift_xor_engine #(
        .WORD_WIDTH (32),
        .TAIL_BITS  (5),
        .NUM_CH     (2),
        .SHIFT_W    (16),
        .IDX_W      (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [31:0] zero, input logic [31:0] last,
                             input logic [31:0] tail, input logic [63:0] acc,
                             input logic [31:0] shift, input logic [9:0] idx);
        bus.word_zero = zero;
        bus.word_last = last;
        bus.word_tail = tail;
        bus.acc_words = acc;
        bus.shift     = shift;
        bus.shift_idx = idx;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("busy_after_accept", 64'(bus.in_ready), 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 64'(n), 64'(LAT));
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, "_ov_low"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_ir_high"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] held;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.word_zero = '0;
        bus.word_last = '0;
        bus.word_tail = '0;
        bus.acc_words = '0;
        bus.shift     = '0;
        bus.shift_idx = '0;

        // Reset state
        #12;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Short-shift lane0, s=0 wrap lane1
        start_req(32'h0000000F, 32'h0, 32'h1F, 64'h0, {16'd5, 16'd3}, {5'd0, 5'd4});
        wait_done("req1_latency");
        check("req1_result", bus.result, 64'hF8000000_0000007F);
        check("req1_err", 64'(bus.err), 64'd0);
        handshake("req1");

        // Illegal lane0, wrap lane1, then backpressure with an ignored request
        start_req(32'h0000000A, 32'hFFFFFFFF, 32'h15, 64'hFFFFFFFF_12345678,
                  {16'd8, 16'd7}, {5'd4, 5'd30});
        wait_done("req2_latency");
        check("req2_result", bus.result, 64'h55000000_12345678);
        check("req2_err", 64'(bus.err), 64'd1);
        held = bus.result;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                bus.word_zero = 32'h0;
                bus.word_tail = 32'h0;
                bus.acc_words = 64'h0;
                bus.in_valid  = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_result_hold", bus.result, held);
            check("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
            check("bp_out_valid_high", 64'(bus.out_valid), 64'd1);
        end
        bus.in_valid = 1'b0;
        check("bp_err_hold", 64'(bus.err), 64'd1);
        handshake("req2");

        // s=0 with all-ones zero word; lane1 short shift with high shift bits set
        start_req(32'hFFFFFFFF, 32'h0, 32'h1F, 64'h00000100_00000000,
                  {16'h0102, 16'd5}, {5'd3, 5'd0});
        wait_done("req3_latency");
        check("req3_result", bus.result, 64'h0000011F_F8000000);
        check("req3_err", 64'(bus.err), 64'd0);
        handshake("req3");

        // Boundary: s=W-T in wrap branch, s=31 in short branch
        start_req(32'h0, 32'hFFFFFFFF, 32'h1F, 64'h000000F0_00000000,
                  {16'd4, 16'd5}, {5'd31, 5'd27});
        wait_done("req4_latency");
        check("req4_result", bus.result, 64'h000000FF_0000001F);
        check("req4_err", 64'(bus.err), 64'd0);
        handshake("req4");

        // Reset during lane-1 EXTRACT
        start_req(32'h0000000F, 32'h0, 32'h1F, 64'h0, {16'd5, 16'd3}, {5'd0, 5'd4});
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_err", 64'(bus.err), 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        start_req(32'h0000000A, 32'hFFFFFFFF, 32'h15, 64'hFFFFFFFF_12345678,
                  {16'd8, 16'd7}, {5'd4, 5'd30});
        wait_done("req5_latency");
        check("req5_result", bus.result, 64'h55000000_12345678);
        check("req5_err", 64'(bus.err), 64'd1);
        handshake("req5");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
